// File: rtl/tmr_fault_monitor_if.sv
// rtl/tmr_fault_monitor_if.sv - voter/monitor signal bundle for tmr_fault_monitor
//
// Ports (as seen from the slave / monitor side):
//   voter_state  in   2      00 agree, 01 A dissents, 10 B dissents, 11 C dissents
//   vote_fail    in   1      no majority among the three cores
//   vote_valid   in   1      qualifies voter_state / vote_fail
//   resync_ack   in   1      reload logic finished resynchronising the core
//   clear        in   1      software clear of counters and state
//   fault_cnt_a/b/c out CNT_W saturating lifetime dissent counts
//   resync_req   out  1      level request to reload resync_core
//   resync_core  out  2      01 A, 10 B, 11 C, 00 when idle
//   halt         out  1      sticky fatal-fault flag
//   mon_state    out  2      current monitor state encoding
interface tmr_fault_monitor_if #(
    parameter int CNT_W = 16
);
    logic [1:0]       voter_state;
    logic             vote_fail;
    logic             vote_valid;
    logic             resync_ack;
    logic             clear;
    logic [CNT_W-1:0] fault_cnt_a;
    logic [CNT_W-1:0] fault_cnt_b;
    logic [CNT_W-1:0] fault_cnt_c;
    logic             resync_req;
    logic [1:0]       resync_core;
    logic             halt;
    logic [1:0]       mon_state;

    modport master (
        output voter_state, vote_fail, vote_valid, resync_ack, clear,
        input  fault_cnt_a, fault_cnt_b, fault_cnt_c,
        input  resync_req, resync_core, halt, mon_state
    );

    modport slave (
        input  voter_state, vote_fail, vote_valid, resync_ack, clear,
        output fault_cnt_a, fault_cnt_b, fault_cnt_c,
        output resync_req, resync_core, halt, mon_state
    );
endinterface

// File: rtl/tmr_fault_monitor.sv
// rtl/tmr_fault_monitor.sv - TMR voter fault monitor with per-core counters and resync/halt FSM
//
// Ports:
//   clk  in  1  single clock, rising edge
//   rst  in  1  synchronous active-high reset
//   mon  tmr_fault_monitor_if.slave  voter inputs, resync handshake, counters and status
//
// Parameters:
//   CNT_W   width of each per-core fault counter
//   THRESH  consecutive dissents by one core that trigger a resync request (2..15)
module tmr_fault_monitor #(
    parameter int CNT_W  = 16,
    parameter int THRESH = 4
) (
    input  logic                clk,
    input  logic                rst,
    tmr_fault_monitor_if.slave  mon
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ALERT  = 2'b01,
        RESYNC = 2'b10,
        HALT   = 2'b11
    } state_t;

    localparam int                 SW       = 4;
    localparam logic [SW-1:0]      THRESH_V = SW'(THRESH);

    state_t                    state_q, state_d;
    logic [2:0][CNT_W-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]             streak_q, streak_d;
    logic [1:0]                streak_core_q, streak_core_d;
    logic                      req_q, req_d;
    logic [1:0]                rcore_q, rcore_d;
    logic                      halt_q, halt_d;

    logic                      sample;
    logic                      dissent;
    logic                      same_core;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign sample    = mon.vote_valid && !mon.vote_fail;
    assign dissent   = sample && (mon.voter_state != 2'b00);
    assign same_core = (mon.voter_state == streak_core_q);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        streak_d      = streak_q;
        streak_core_d = streak_core_q;

        if (mon.clear) begin
            state_d       = IDLE;
            cnt_d         = '0;
            streak_d      = '0;
            streak_core_d = 2'b00;
        end else if (state_q == HALT) begin
            // sticky: counters and streak frozen until clear/reset
        end else if (mon.vote_valid && mon.vote_fail) begin
            state_d = HALT;
        end else begin
            if (dissent) begin
                case (mon.voter_state)
                    2'b01:   cnt_d[0] = sat_inc(cnt_q[0]);
                    2'b10:   cnt_d[1] = sat_inc(cnt_q[1]);
                    default: cnt_d[2] = sat_inc(cnt_q[2]);
                endcase
            end

            if (sample) begin
                if (mon.voter_state == 2'b00) begin
                    streak_d = '0;
                end else if (same_core) begin
                    streak_d = (streak_q >= THRESH_V) ? THRESH_V : streak_q + 1'b1;
                end else begin
                    streak_d      = SW'(1);
                    streak_core_d = mon.voter_state;
                end
            end

            case (state_q)
                IDLE: begin
                    if (dissent) state_d = ALERT;
                end
                ALERT: begin
                    if (sample && !dissent)
                        state_d = IDLE;
                    else if (dissent && streak_d == THRESH_V)
                        state_d = RESYNC;
                end
                RESYNC: begin
                    // ack beats a same-cycle foreign dissent; the dissent is still counted above
                    if (mon.resync_ack) begin
                        state_d  = IDLE;
                        streak_d = '0;
                    end else if (dissent && !same_core) begin
                        state_d = HALT;
                    end
                end
                default: ;
            endcase
        end

        // Outputs are registered copies derived from the next state
        req_d   = (state_d == RESYNC);
        rcore_d = (state_d == RESYNC) ? streak_core_d : 2'b00;
        halt_d  = (state_d == HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            streak_q      <= '0;
            streak_core_q <= 2'b00;
            req_q         <= 1'b0;
            rcore_q       <= 2'b00;
            halt_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            streak_q      <= streak_d;
            streak_core_q <= streak_core_d;
            req_q         <= req_d;
            rcore_q       <= rcore_d;
            halt_q        <= halt_d;
        end
    end

    assign mon.fault_cnt_a = cnt_q[0];
    assign mon.fault_cnt_b = cnt_q[1];
    assign mon.fault_cnt_c = cnt_q[2];
    assign mon.resync_req  = req_q;
    assign mon.resync_core = rcore_q;
    assign mon.halt        = halt_q;
    assign mon.mon_state   = state_q;

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// tb/tb_tmr_fault_monitor.sv - self-checking bench for tmr_fault_monitor
module tb_tmr_fault_monitor;
    localparam int THRESH = 4;
    localparam int CMAX   = 65535;

    logic clk = 1'b0;
    logic rst;
    logic rst_s;

    always #5 clk = ~clk;

    tmr_fault_monitor_if #(.CNT_W(16)) mif ();
    tmr_fault_monitor_if #(.CNT_W(4))  sif ();

    tmr_fault_monitor #(.CNT_W(16), .THRESH(THRESH)) u_dut (
        .clk (clk),
        .rst (rst),
        .mon (mif.slave)
    );

    tmr_fault_monitor #(.CNT_W(4), .THRESH(THRESH)) u_sat (
        .clk (clk),
        .rst (rst_s),
        .mon (sif.slave)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic r, c, v, f;
        logic [1:0] s;
        logic a;
        logic [1:0] st;
        logic req;
        logic [1:0] core;
        logic halt;
        int ca, cb, cc;
    } vec_t;

    vec_t tbl[$];

    int m_state, m_streak, m_core;
    int m_cnt[3];

    function automatic vec_t mk(input logic r, c, v, f, input logic [1:0] s, input logic a,
                                input logic [1:0] st, input logic req, input logic [1:0] core,
                                input logic halt, input int ca, cb, cc);
        vec_t t;
        t.r = r; t.c = c; t.v = v; t.f = f; t.s = s; t.a = a;
        t.st = st; t.req = req; t.core = core; t.halt = halt;
        t.ca = ca; t.cb = cb; t.cc = cc;
        return t;
    endfunction

    function automatic logic [63:0] dut_pack();
        return {10'd0, mif.mon_state, mif.resync_req, mif.resync_core, mif.halt,
                mif.fault_cnt_a, mif.fault_cnt_b, mif.fault_cnt_c};
    endfunction

    function automatic logic [63:0] model_pack();
        logic [1:0] core;
        core = (m_state == 2) ? 2'(m_core) : 2'd0;
        return {10'd0, 2'(m_state), (m_state == 2), core, (m_state == 3),
                16'(m_cnt[0]), 16'(m_cnt[1]), 16'(m_cnt[2])};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic apply(input logic r, c, v, f, input logic [1:0] s, input logic a);
        rst             = r;
        mif.clear       = c;
        mif.vote_valid  = v;
        mif.vote_fail   = f;
        mif.voter_state = s;
        mif.resync_ack  = a;
        @(posedge clk);
        #1;
    endtask

    // Reference model: one call per clock with the inputs seen at that edge
    task automatic model_step(input logic r, c, v, f, input logic [1:0] s, input logic a);
        bit dissent, foreign;
        int k;
        if (r || c) begin
            m_state = 0; m_streak = 0; m_core = 0;
            m_cnt = '{0, 0, 0};
            return;
        end
        if (m_state == 3) return;
        if (v && f) begin
            m_state = 3;
            return;
        end
        dissent = v && (s != 2'b00);
        foreign = dissent && (int'(s) != m_core);
        if (dissent) begin
            k = int'(s) - 1;
            m_cnt[k] = (m_cnt[k] < CMAX) ? m_cnt[k] + 1 : CMAX;
        end
        if (v) begin
            if (s == 2'b00)   m_streak = 0;
            else if (!foreign) m_streak = (m_streak < THRESH) ? m_streak + 1 : THRESH;
            else begin
                m_streak = 1;
                m_core   = int'(s);
            end
        end
        case (m_state)
            0: if (dissent) m_state = 1;
            1: begin
                if (v && s == 2'b00)          m_state = 0;
                else if (m_streak == THRESH)  m_state = 2;
            end
            2: begin
                if (a) begin
                    m_state  = 0;
                    m_streak = 0;
                end else if (foreign) begin
                    m_state = 3;
                end
            end
            default: ;
        endcase
    endtask

    task automatic sat_apply(input logic r, v, input logic [1:0] s);
        rst_s           = r;
        sif.vote_valid  = v;
        sif.voter_state = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic r, c, v, f, a;
        logic [1:0] s, last_s;
        logic [63:0] exp;

        rst = 1'b1; rst_s = 1'b1;
        mif.clear = 0; mif.vote_valid = 0; mif.vote_fail = 0; mif.voter_state = 0; mif.resync_ack = 0;
        sif.clear = 0; sif.vote_valid = 0; sif.vote_fail = 0; sif.voter_state = 0; sif.resync_ack = 0;

        //             r  c  v  f  s  a    st req core halt ca cb cc
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 2, 0,  1, 0, 0, 0,  0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 2, 0,  1, 0, 0, 0,  0, 2, 0));
        tbl.push_back(mk(0, 0, 1, 0, 2, 0,  1, 0, 0, 0,  0, 3, 0));
        tbl.push_back(mk(0, 0, 1, 0, 2, 0,  2, 1, 2, 0,  0, 4, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0,  2, 1, 2, 0,  0, 4, 0));
        tbl.push_back(mk(0, 0, 0, 1, 3, 0,  2, 1, 2, 0,  0, 4, 0));
        tbl.push_back(mk(0, 0, 1, 0, 2, 0,  2, 1, 2, 0,  0, 5, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0,  0, 5, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0,  0, 5, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0,  1, 0, 0, 0,  1, 5, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0,  1, 0, 0, 0,  2, 5, 0));
        tbl.push_back(mk(0, 0, 1, 0, 2, 0,  1, 0, 0, 0,  2, 6, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0,  1, 0, 0, 0,  3, 6, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0, 0, 0,  3, 6, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0,  1, 0, 0, 0,  4, 6, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0,  1, 0, 0, 0,  5, 6, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0,  1, 0, 0, 0,  6, 6, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0,  2, 1, 1, 0,  7, 6, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0,  2, 1, 1, 0,  8, 6, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0,  2, 1, 1, 0,  8, 6, 0));
        tbl.push_back(mk(0, 0, 1, 0, 3, 0,  3, 0, 0, 1,  8, 6, 1));
        tbl.push_back(mk(0, 0, 1, 0, 3, 0,  3, 0, 0, 1,  8, 6, 1));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0,  3, 0, 0, 1,  8, 6, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,  3, 0, 0, 1,  8, 6, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0,  0, 0, 0, 0,  0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0,  0, 0, 0, 0,  0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 2, 0,  3, 0, 0, 1,  0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 3, 0,  1, 0, 0, 0,  0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 3, 0,  1, 0, 0, 0,  0, 0, 2));
        tbl.push_back(mk(0, 0, 1, 0, 3, 0,  1, 0, 0, 0,  0, 0, 3));
        tbl.push_back(mk(0, 0, 1, 0, 3, 0,  2, 1, 3, 0,  0, 0, 4));
        tbl.push_back(mk(0, 0, 1, 0, 1, 1,  0, 0, 0, 0,  1, 0, 4));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0,  1, 0, 0, 0,  2, 0, 4));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0,  1, 0, 0, 0,  3, 0, 4));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0,  1, 0, 0, 0,  4, 0, 4));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0,  2, 1, 1, 0,  5, 0, 4));
        tbl.push_back(mk(1, 1, 1, 0, 2, 1,  0, 0, 0, 0,  0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 2, 0,  1, 0, 0, 0,  0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0,  1, 0, 0, 0,  0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 2, 0,  0, 0, 0, 0,  0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 2, 0,  1, 0, 0, 0,  0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0,  3, 0, 0, 1,  0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0));

        foreach (tbl[i]) begin
            apply(tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].f, tbl[i].s, tbl[i].a);
            exp = {10'd0, tbl[i].st, tbl[i].req, tbl[i].core, tbl[i].halt,
                   16'(tbl[i].ca), 16'(tbl[i].cb), 16'(tbl[i].cc)};
            check($sformatf("vec[%0d]", i), dut_pack(), exp);
        end

        // Request must stay put for a long ack-less wait, then drop one cycle after ack
        apply(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) apply(0, 0, 1, 0, 2'b10, 0);
        check("resync_entry", {mif.mon_state, mif.resync_req, mif.resync_core, mif.fault_cnt_b},
              {2'b10, 1'b1, 2'b10, 16'd4});
        for (int i = 0; i < 10; i++) begin
            apply(0, 0, 0, 0, 0, 0);
            check($sformatf("resync_hold[%0d]", i), {mif.mon_state, mif.resync_req, mif.resync_core},
                  {2'b10, 1'b1, 2'b10});
        end
        apply(0, 0, 0, 0, 0, 1);
        check("resync_ack", {mif.mon_state, mif.resync_req, mif.resync_core}, {2'b00, 1'b0, 2'b00});

        // Saturation on the narrow instance: 14 then three more samples must stick at all-ones
        sat_apply(1, 0, 0);
        for (int i = 0; i < 14; i++) sat_apply(0, 1, 2'b11);
        check("sat_preload", {28'd0, sif.fault_cnt_c}, 32'd14);
        for (int i = 0; i < 3; i++) begin
            sat_apply(0, 1, 2'b11);
            check($sformatf("sat_hold[%0d]", i), {28'd0, sif.fault_cnt_c}, 32'd15);
        end
        check("sat_others", {sif.fault_cnt_a, sif.fault_cnt_b, sif.halt}, 9'd0);

        // Randomised run against the model
        apply(1, 0, 0, 0, 0, 0);
        model_step(1, 0, 0, 0, 0, 0);
        last_s = 2'b01;
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 299) == 0);
            c = ($urandom_range(0, 59) == 0);
            v = ($urandom_range(0, 9) < 7);
            f = ($urandom_range(0, 49) == 0);
            a = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 1) s = last_s;
            else s = 2'($urandom_range(0, 3));
            last_s = s;
            apply(r, c, v, f, s, a);
            model_step(r, c, v, f, s, a);
            check($sformatf("rand[%0d]", i), dut_pack(), model_pack());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tmr_fault_monitor.md
TMR_FAULT_MONITOR -- requirements
Module: tmr_fault_monitor

Interface
REQ-001 Parameter CNT_W, 16, width of each per-core fault counter.
REQ-002 Parameter THRESH, 4, consecutive dissents by one core that trigger a resync request; legal range 2..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 Voter_state  input  2  voter outcome: 00 all agree, 01 core A dissents, 10 core B dissents, 11 core C dissents.
REQ-006 Vote_fail  input  1  no two cores agree (no majority).
REQ-007 Vote_valid  input  1  Voter_state/Vote_fail are sampled only when high.
REQ-008 Resync_ack  input  1  core-reload logic has finished resynchronising the dissenting core.
REQ-009 Clear  input  1  software clear of counters and state.
REQ-010 Fault_cnt_A, Fault_cnt_B, Fault_cnt_C  output  CNT_W each  saturating lifetime dissent counts per core.
REQ-011 Resync_req  output  1  level request to reload the core named on Resync_core.
REQ-012 Resync_core  output  2  01 A, 10 B, 11 C; 00 when no request.
REQ-013 Halt  output  1  sticky fatal-fault flag.
REQ-014 Mon_state  output  2  current FSM state encoding.

Function
REQ-015 The FSM SHALL have states IDLE=00, ALERT=01, RESYNC=10, HALT=11; all outputs are registered.
REQ-016 A valid dissent (Vote_valid=1, Voter_state!=00, Vote_fail=0) SHALL increment the dissenting core's counter by 1, saturating at all-ones, in every state except HALT.
REQ-017 Streak tracking: on a valid dissent by the same core as streak_core, streak increments (saturating at THRESH); by a different core, streak=1 and streak_core=that core; on valid 00, streak=0.
REQ-018 IDLE -> ALERT on a valid dissent; ALERT -> IDLE on a valid 00.
REQ-019 ALERT -> RESYNC on the valid sample that brings streak to THRESH; Resync_req=1 and Resync_core=streak_core from the next cycle (1-cycle latency).
REQ-020 In RESYNC, Resync_req and Resync_core SHALL hold stable until Resync_ack is sampled high; the FSM then goes to IDLE, streak clears, and Resync_req drops on the following cycle.
REQ-021 In RESYNC, a valid dissent by the core being resynced SHALL count but not change state; a valid dissent by any other core SHALL force HALT.
REQ-022 Vote_fail=1 with Vote_valid=1 SHALL force HALT from any state; counters SHALL NOT change on that sample.
REQ-023 HALT SHALL be sticky: Halt=1, Resync_req=0, Resync_core=00, counters frozen, until rst or Clear.
REQ-024 Resync_ack outside RESYNC SHALL be ignored.
REQ-025 Vote_valid=0 SHALL cause no counter, streak or transition change; Resync_ack and Clear remain effective.
REQ-026 Clear SHALL have priority over every same-cycle event: next cycle counters=0, streak=0, state=IDLE, Halt=0, Resync_req=0.
REQ-027 Resync_ack and a triggering dissent in the same RESYNC cycle: ack wins, state goes to IDLE with streak=0, and the dissent is still counted.

Reset
REQ-028 On rst=1 at a clock edge, next cycle: Mon_state=00, all Fault_cnt=0, Resync_req=0, Resync_core=00, Halt=0, streak=0, streak_core=00.
REQ-029 rst SHALL override Clear and all inputs; reset mid-RESYNC drops Resync_req without waiting for Resync_ack.

Verification
REQ-030 Four valid samples of 10 -> Fault_cnt_B=4, Mon_state 01 after first, Resync_req=1 and Resync_core=10 one cycle after fourth.
REQ-031 In RESYNC, hold Resync_ack=0 for 10 cycles -> request stable; pulse ack -> Mon_state=00 next cycle, Resync_req=0.
REQ-032 Dissent pattern 01,01,10,01 -> no resync, streak=1 on A, Fault_cnt_A=3, Fault_cnt_B=1.
REQ-033 In RESYNC for A, valid sample 11 -> Halt=1, Mon_state=11; further samples leave counters frozen; Clear -> all zero, IDLE.
REQ-034 Preload Fault_cnt_C to 16'hFFFE, apply three valid 11 samples -> counter reads 16'hFFFF, no wrap.
REQ-035 Vote_fail=1 with Clear=1 same cycle -> IDLE, Halt=0; Vote_fail=1 with Vote_valid=0 -> no change.
